// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states, queued command entry.
// No logic; the entry field widths set the default widths of the sequencer.
// Not applicable (definitions only).
package alu_pkg;

  localparam int CMD_DATA_W = 16;
  localparam int CMD_RPT_W  = 4;

  localparam logic [2:0] OP_INC    = 3'b000;
  localparam logic [2:0] OP_DEC    = 3'b001;
  localparam logic [2:0] OP_INV    = 3'b010;
  localparam logic [2:0] OP_REDAND = 3'b011;
  localparam logic [2:0] OP_REDOR  = 3'b100;
  localparam logic [2:0] OP_TEMP0  = 3'b101;
  localparam logic [2:0] OP_TEMP1  = 3'b110;
  localparam logic [2:0] OP_NOP    = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  typedef struct packed {
    logic [2:0]            op;
    logic [CMD_DATA_W-1:0] data;
    logic [CMD_RPT_W-1:0]  rpt;
  } cmd_entry_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO with full/empty flags; read data is the head entry, shown combinationally.
// Latency: an entry pushed at one edge is visible at the head after that edge.
// Backpressure: push ignored while full, pop ignored while empty; push+pop together keeps the count.
module alu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array: written on accepted pushes, not reset (pointers define validity).
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues host ALU commands, iterates each through the ALU RPT times, returns the final result.
// Latency: accept->pop 1 cycle, RPT*(ALU_LAT+1) cycles of EXEC, one bubble after each response.
// Backpressure: CMD_READY drops when the FIFO is full; RSP fields hold until RSP_READY is seen.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W     = CMD_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int RPT_W      = CMD_RPT_W,
  parameter int ALU_LAT    = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [2:0]        CMD_OP,
  input  logic [DATA_W-1:0] CMD_DATA,
  input  logic [RPT_W-1:0]  CMD_RPT,
  output logic [DATA_W-1:0] ALU_IN0,
  output logic [DATA_W-1:0] ALU_IN1,
  output logic [2:0]        CMD_OUT,
  input  logic [DATA_W-1:0] ALU_RES,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_DATA,
  output logic [2:0]        RSP_OP,
  output logic              BUSY
);

  // Latency counter only needs to reach ALU_LAT; keep at least one bit.
  localparam int             LAT_W    = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ALU_LAT);

  state_t            state;
  logic [DATA_W-1:0] opr;
  logic [2:0]        op;
  logic [RPT_W-1:0]  iter;
  logic [LAT_W-1:0]  lat_cnt;
  logic [2:0]        cmd_out_q;
  logic              rsp_valid_q;

  cmd_entry_t        wr_entry;
  cmd_entry_t        rd_entry;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;

  assign wr_entry.op   = CMD_OP;
  assign wr_entry.data = CMD_DATA;
  assign wr_entry.rpt  = CMD_RPT;

  assign CMD_READY = !fifo_full;
  assign fifo_push = CMD_VALID && !fifo_full;
  // The FSM takes the head entry whenever it is idle and something is queued.
  assign fifo_pop  = (state == IDLE) && !fifo_empty;

  alu_cmd_fifo #(
    .WIDTH ($bits(cmd_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .push    (fifo_push),
    .wr_data (wr_entry),
    .pop     (fifo_pop),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // The operand register feeds the ALU directly; it only changes on load or on result capture.
  assign ALU_IN0   = opr;
  assign ALU_IN1   = '0;
  assign CMD_OUT   = cmd_out_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = opr;
  assign RSP_OP    = op;
  assign BUSY      = (state != IDLE) || !fifo_empty;

  // Command FSM: load from FIFO, iterate through the ALU, then hold the response until taken.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      opr         <= '0;
      op          <= OP_NOP;
      iter        <= '0;
      lat_cnt     <= '0;
      cmd_out_q   <= OP_NOP;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            opr     <= rd_entry.data;
            op      <= rd_entry.op;
            iter    <= rd_entry.rpt;
            lat_cnt <= '0;
            if (rd_entry.rpt == '0) begin
              // Zero repeat: nothing goes to the ALU, the operand is returned as-is.
              state       <= RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state     <= EXEC;
              cmd_out_q <= rd_entry.op;
            end
          end
        end
        EXEC: begin
          if (lat_cnt == LAT_LAST) begin
            opr     <= ALU_RES;
            iter    <= iter - 1'b1;
            lat_cnt <= '0;
            if (iter == RPT_W'(1)) begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              cmd_out_q   <= OP_NOP;
            end
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        RESP: begin
          if (RSP_READY) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          cmd_out_q   <= OP_NOP;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
